// File: rtl/calc_pkg.sv
// Shared key codes, operation codes, FSM states and digit-entry helper
// for the keypad calculator sequencer.
package calc_pkg;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_AST  = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_sel_t;

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_ISSUE,
        S_WAIT,
        S_SHOW
    } state_t;

    // Shift a new decimal digit into a 2-digit operand; result stays in 0..99.
    function automatic logic [6:0] shift_digit(input logic [6:0] cur, input logic [3:0] d);
        logic [6:0] low;
        low = cur % 7'd10;
        return low * 7'd10 + {3'b000, d};
    endfunction

    function automatic op_sel_t sel_of(input logic [3:0] code);
        case (code)
            KEY_B:   return OP_SUB;
            KEY_C:   return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_sequencer_debounce.sv
// Keypad debouncer: one event per press, requires stable single key and
// a stable all-released period before re-arming.
module key_debounce_encoder #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keys_n,
    output logic        key_evt,
    output logic [3:0]  key_code
);

    localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);

    logic [4:0] low_cnt;
    logic [3:0] low_idx;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic [3:0] cand;
    logic       armed;

    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (!keys_n[i]) begin
                low_cnt = low_cnt + 5'd1;
                low_idx = 4'(i);
            end
        end
    end

    assign cnt_inc = cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            cand     <= '0;
            armed    <= 1'b1;
            key_evt  <= 1'b0;
            key_code <= '0;
        end else begin
            key_evt <= 1'b0;
            if (!armed) begin
                // Re-arm only after every line has read high long enough.
                if (low_cnt == 5'd0) begin
                    if (cnt_inc == DB) begin
                        armed <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end else begin
                    cnt <= '0;
                end
            end else if (low_cnt == 5'd1) begin
                if (cnt != 8'd0 && low_idx == cand) begin
                    if (cnt_inc == DB) begin
                        key_evt  <= 1'b1;
                        key_code <= low_idx;
                        armed    <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end else begin
                    cand <= low_idx;
                    if (DB == 8'd1) begin
                        key_evt  <= 1'b1;
                        key_code <= low_idx;
                        armed    <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= 8'd1;
                    end
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator controller: operand entry from debounced keys, start/done
// handshake to the arithmetic unit, result latching and timeout.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keys_n,
    output logic [6:0]  op_a,
    output logic [6:0]  op_b,
    output logic [1:0]  op_sel,
    output logic        op_start,
    input  logic        alu_done,
    input  logic [13:0] alu_result,
    input  logic        alu_sign,
    output logic [13:0] resultado,
    output logic        sinal,
    output logic        entry_b,
    output logic        busy,
    output logic        err
);

    localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);

    state_t      state, state_n;
    op_sel_t     sel_q, sel_n;
    logic [6:0]  op_a_n, op_b_n;
    logic [13:0] res_n;
    logic        sign_n, err_n;
    logic [15:0] tmo, tmo_n;
    logic        key_evt, evt_q;
    logic [3:0]  key_code, code_q;
    logic        is_digit, is_op;

    key_debounce_encoder #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk      (clk),
        .rst      (rst),
        .keys_n   (keys_n),
        .key_evt  (key_evt),
        .key_code (key_code)
    );

    assign is_digit = (code_q <= 4'd9);
    assign is_op    = (code_q >= KEY_A) && (code_q <= KEY_C);
    assign op_sel   = sel_q;
    assign op_start = (state == S_ISSUE);
    assign busy     = (state == S_ISSUE) || (state == S_WAIT);
    assign entry_b  = (state == S_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_A;
            op_a      <= '0;
            op_b      <= '0;
            sel_q     <= OP_ADD;
            resultado <= '0;
            sinal     <= 1'b0;
            err       <= 1'b0;
            tmo       <= '0;
            evt_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            state     <= state_n;
            op_a      <= op_a_n;
            op_b      <= op_b_n;
            sel_q     <= sel_n;
            resultado <= res_n;
            sinal     <= sign_n;
            err       <= err_n;
            tmo       <= tmo_n;
            evt_q     <= key_evt;
            code_q    <= key_code;
        end
    end

    always_comb begin
        state_n = state;
        op_a_n  = op_a;
        op_b_n  = op_b;
        sel_n   = sel_q;
        res_n   = resultado;
        sign_n  = sinal;
        err_n   = err;
        tmo_n   = tmo;
        case (state)
            S_A, S_B: begin
                if (evt_q) begin
                    if (is_digit) begin
                        if (state == S_A) op_a_n = shift_digit(op_a, code_q);
                        else              op_b_n = shift_digit(op_b, code_q);
                    end else if (is_op) begin
                        sel_n   = sel_of(code_q);
                        state_n = S_ISSUE;
                    end else if (code_q == KEY_D) begin
                        op_a_n  = '0;
                        op_b_n  = '0;
                        res_n   = '0;
                        sign_n  = 1'b0;
                        err_n   = 1'b0;
                        state_n = S_A;
                    end else if (code_q == KEY_AST) begin
                        if (state == S_A) op_a_n = '0;
                        else              state_n = S_A;
                    end else begin
                        state_n = S_B;
                    end
                end
            end
            S_ISSUE: begin
                err_n   = 1'b0;
                tmo_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done) begin
                    res_n   = alu_result;
                    sign_n  = alu_sign;
                    state_n = S_SHOW;
                end else if (tmo + 16'd1 == TO) begin
                    err_n   = 1'b1;
                    state_n = S_SHOW;
                end else begin
                    tmo_n = tmo + 16'd1;
                end
            end
            S_SHOW: begin
                if (evt_q) begin
                    if (is_digit) begin
                        op_a_n  = {3'b000, code_q};
                        op_b_n  = '0;
                        state_n = S_A;
                    end else if (is_op) begin
                        sel_n   = sel_of(code_q);
                        state_n = S_ISSUE;
                    end else if (code_q == KEY_D) begin
                        op_a_n  = '0;
                        op_b_n  = '0;
                        res_n   = '0;
                        sign_n  = 1'b0;
                        err_n   = 1'b0;
                        state_n = S_A;
                    end else if (code_q == KEY_AST) begin
                        state_n = S_A;
                    end else begin
                        state_n = S_B;
                    end
                end
            end
            default: state_n = S_A;
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus random
// key sequences against a behavioural calculator model.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int DB = 4;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keys_n;
    logic [6:0]  op_a, op_b;
    logic [1:0]  op_sel;
    logic        op_start, alu_done, alu_sign;
    logic [13:0] alu_result, resultado;
    logic        sinal, entry_b, busy, err;

    int tests = 0;
    int fails = 0;

    calc_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keys_n     (keys_n),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sel     (op_sel),
        .op_start   (op_start),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_sign   (alu_sign),
        .resultado  (resultado),
        .sinal      (sinal),
        .entry_b    (entry_b),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Arithmetic-unit responder
    bit          alu_never = 1'b0;
    bit          alu_fixed = 1'b0;
    int          alu_delay = 3;
    int          pend = 0;
    int          starts = 0;
    int          ra, rb;
    logic [13:0] pres;
    logic        psign;

    initial begin
        alu_done = 1'b0; alu_result = '0; alu_sign = 1'b0;
        forever begin
            @(negedge clk);
            alu_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    alu_done = 1'b1; alu_result = pres; alu_sign = psign;
                end
            end
            if (op_start === 1'b1) begin
                starts++;
                if (!alu_never) begin
                    pend = alu_delay;
                    ra = int'(op_a); rb = int'(op_b);
                    if (alu_fixed) begin
                        pres = 14'd7; psign = 1'b1;
                    end else if (op_sel == 2'd0) begin
                        pres = 14'(ra + rb); psign = 1'b0;
                    end else if (op_sel == 2'd1) begin
                        pres = 14'(ra >= rb ? ra - rb : rb - ra); psign = (ra < rb);
                    end else begin
                        pres = 14'(ra * rb); psign = 1'b0;
                    end
                end
            end
        end
    end

    // Observers: debounced events and busy-run length
    int evt_cnt = 0;
    int run = 0;
    int last_run = 0;
    initial forever begin
        @(negedge clk);
        if (dut.u_deb.key_evt === 1'b1) evt_cnt++;
        if (busy === 1'b1) run++;
        else if (run != 0) begin last_run = run; run = 0; end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
        $fatal(1, "watchdog");
    end

    // Behavioural model: 0 = entering A, 1 = entering B, 2 = showing result
    int ms, ma, mb, msel, mres, msign, merr;

    task automatic model_reset();
        ms = 0; ma = 0; mb = 0; msel = 0; mres = 0; msign = 0; merr = 0;
    endtask

    task automatic model_key(input int k);
        bit issue = 1'b0;
        if (k == 13) begin
            ma = 0; mb = 0; mres = 0; msign = 0; merr = 0; ms = 0;
        end else if (k >= 10 && k <= 12) begin
            msel = k - 10; issue = 1'b1;
        end else if (ms == 2) begin
            if (k < 10) begin ma = k; mb = 0; ms = 0; end
            else if (k == 14) ms = 0;
            else ms = 1;
        end else begin
            if (k < 10) begin
                if (ms == 0) ma = (ma % 10) * 10 + k;
                else         mb = (mb % 10) * 10 + k;
            end else if (k == 14) begin
                if (ms == 0) ma = 0; else ms = 0;
            end else begin
                ms = 1;
            end
        end
        if (issue) begin
            merr = 0; ms = 2;
            if (alu_never) merr = 1;
            else if (alu_fixed) begin mres = 7; msign = 1; end
            else if (msel == 0) begin mres = ma + mb; msign = 0; end
            else if (msel == 1) begin
                mres = (ma >= mb) ? ma - mb : mb - ma; msign = (ma < mb) ? 1 : 0;
            end else begin mres = ma * mb; msign = 0; end
        end
    endtask

    task automatic press(input int k);
        keys_n = '1;
        keys_n[k] = 1'b0;
        repeat (10) @(negedge clk);
        keys_n = '1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy === 1'b1 && n < 300) begin @(negedge clk); n++; end
        @(negedge clk);
        ok = (busy === 1'b0);
    endtask

    task automatic key(input int k);
        bit ok;
        model_key(k);
        press(k);
        if (k >= 10 && k <= 12) begin
            wait_idle(ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL idle_wait: busy=%b required=0", busy); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; keys_n = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        tests++;
        if ({op_a, op_b, op_sel, resultado} !== '0) begin
            fails++; $display("FAIL reset_regs: a=%0d b=%0d sel=%0d res=%0d required=0", op_a, op_b, op_sel, resultado);
        end
        tests++;
        if ({sinal, op_start, busy, err, entry_b} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got=%b required=00000", {sinal, op_start, busy, err, entry_b});
        end
    endtask

    task automatic test_add();
        int s0 = starts;
        key(1); key(2); key(15);
        tests++;
        if (entry_b !== 1'b1) begin fails++; $display("FAIL add_entry_b: got=%b required=1", entry_b); end
        key(3); key(4); key(10);
        tests++;
        if (op_a !== 7'd12 || op_b !== 7'd34) begin
            fails++; $display("FAIL add_operands: a=%0d b=%0d required 12 34", op_a, op_b);
        end
        tests++;
        if (op_sel !== 2'd0) begin fails++; $display("FAIL add_sel: got=%0d required=0", op_sel); end
        tests++;
        if (starts - s0 != 1) begin fails++; $display("FAIL add_start_count: got=%0d required=1", starts - s0); end
        tests++;
        if (resultado !== 14'd46 || sinal !== 1'b0) begin
            fails++; $display("FAIL add_result: res=%0d sign=%b required 46 0", resultado, sinal);
        end
    endtask

    task automatic test_sub_mul();
        key(5); key(15); key(1); key(2);
        alu_fixed = 1'b1;
        key(11);
        alu_fixed = 1'b0;
        tests++;
        if (op_sel !== 2'd1 || resultado !== 14'd7 || sinal !== 1'b1) begin
            fails++; $display("FAIL sub_result: sel=%0d res=%0d sign=%b required 1 7 1", op_sel, resultado, sinal);
        end
        key(12);
        tests++;
        if (op_sel !== 2'd2 || resultado !== 14'd60 || sinal !== 1'b0) begin
            fails++; $display("FAIL mul_reissue: sel=%0d res=%0d sign=%b required 2 60 0", op_sel, resultado, sinal);
        end
    endtask

    task automatic test_99();
        key(9); key(9); key(9);
        tests++;
        if (op_a !== 7'd99) begin fails++; $display("FAIL shift_99: a=%0d required=99", op_a); end
        key(15); key(9); key(9); key(12);
        tests++;
        if (op_b !== 7'd99 || resultado !== 14'd9801) begin
            fails++; $display("FAIL mul_99: b=%0d res=%0d required 99 9801", op_b, resultado);
        end
    endtask

    task automatic test_timeout();
        alu_never = 1'b1;
        key(10);
        alu_never = 1'b0;
        tests++;
        if (last_run < TO || last_run > TO + 1) begin
            fails++; $display("FAIL timeout_busy_len: got=%0d required=%0d..%0d", last_run, TO, TO + 1);
        end
        tests++;
        if (err !== 1'b1 || resultado !== 14'd9801 || sinal !== 1'b0) begin
            fails++; $display("FAIL timeout_err: err=%b res=%0d sign=%b required 1 9801 0", err, resultado, sinal);
        end
        key(13);
        tests++;
        if ({op_a, op_b, resultado, sinal, err, entry_b} !== '0) begin
            fails++; $display("FAIL clear_d: a=%0d b=%0d res=%0d sign=%b err=%b eb=%b required all 0",
                              op_a, op_b, resultado, sinal, err, entry_b);
        end
    endtask

    task automatic test_glitch();
        int e0 = evt_cnt;
        keys_n = '1; keys_n[3] = 1'b0;
        repeat (DB - 1) @(negedge clk);
        keys_n[4] = 1'b0;
        repeat (20) @(negedge clk);
        keys_n = '1;
        repeat (10) @(negedge clk);
        tests++;
        if (evt_cnt != e0 || op_a !== 7'd0) begin
            fails++; $display("FAIL glitch: events=%0d a=%0d required 0 0", evt_cnt - e0, op_a);
        end
    endtask

    task automatic test_random();
        int k, r;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 19);
            if (r < 13) k = r;
            else if (r < 15) k = 14;
            else if (r < 17) k = 15;
            else if (r == 17) k = 13;
            else k = $urandom_range(0, 9);
            key(k);
            tests++;
            if (op_a !== 7'(ma) || op_b !== 7'(mb)) begin
                fails++; $display("FAIL rnd_operands[%0d] key=%0d: a=%0d b=%0d required %0d %0d", i, k, op_a, op_b, ma, mb);
            end
            tests++;
            if (entry_b !== (ms == 1) || busy !== 1'b0 || op_sel !== 2'(msel)) begin
                fails++; $display("FAIL rnd_state[%0d] key=%0d: eb=%b busy=%b sel=%0d required %0d 0 %0d",
                                  i, k, entry_b, busy, op_sel, (ms == 1), msel);
            end
            tests++;
            if (resultado !== 14'(mres) || sinal !== 1'(msign) || err !== 1'(merr)) begin
                fails++; $display("FAIL rnd_result[%0d] key=%0d: res=%0d sign=%b err=%b required %0d %0d %0d",
                                  i, k, resultado, sinal, err, mres, msign, merr);
            end
        end
    endtask

    task automatic test_reset_abort();
        int n = 0;
        int s0;
        key(13); key(2); key(10);
        tests++;
        if (resultado !== 14'd2) begin fails++; $display("FAIL pre_abort_result: got=%0d required=2", resultado); end
        alu_delay = 5;
        keys_n = '1; keys_n[10] = 1'b0;
        while (op_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (op_start !== 1'b1) begin fails++; $display("FAIL abort_start_seen: got=%b required=1", op_start); end
        repeat (2) @(negedge clk);
        rst = 1'b1; keys_n = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        s0 = starts;
        tests++;
        if (busy !== 1'b0 || entry_b !== 1'b0 || resultado !== '0 || op_a !== '0) begin
            fails++; $display("FAIL abort_state: busy=%b eb=%b res=%0d a=%0d required 0 0 0 0", busy, entry_b, resultado, op_a);
        end
        repeat (20) @(negedge clk);
        tests++;
        if (starts != s0 || resultado !== '0 || busy !== 1'b0) begin
            fails++; $display("FAIL abort_no_start: starts=%0d res=%0d busy=%b required 0 0 0", starts - s0, resultado, busy);
        end
        alu_delay = 3;
    endtask

    initial begin
        rst = 1'b1; keys_n = '1;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_mul();
        test_99();
        test_timeout();
        test_glitch();
        test_random();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Controller for the two-operand keypad calculator datapath. It debounces the 16 active-low keypad lines and builds two 2-digit decimal operands. It issues add/sub/mult requests to the arithmetic unit over a start/done handshake, then latches the result and sign for display. It sits between the raw keypad pins and the arithmetic unit and replaces ad-hoc level-sensitive key handling with clocked, one-event-per-press sequencing.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a key press is accepted (1..255)
TIMEOUT_CYCLES, 64, cycles to wait for alu_done before aborting (1..65535)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
keys_n  in  16  active-low keys; [9:0] digits 0-9, [10] A, [11] B, [12] C, [13] D, [14] *, [15] #
op_a  out  7  operand A, 0..99
op_b  out  7  operand B, 0..99
op_sel  out  2  0 add, 1 sub, 2 mult; 3 never driven
op_start  out  1  one-cycle request pulse to arithmetic unit
alu_done  in  1  arithmetic unit completion, one-cycle pulse
alu_result  in  14  magnitude from arithmetic unit, valid with alu_done
alu_sign  in  1  1 = negative, valid with alu_done
resultado  out  14  latched result magnitude
sinal  out  1  latched result sign
entry_b  out  1  1 while operand B is being edited
busy  out  1  1 in S_ISSUE/S_WAIT
err  out  1  sticky timeout flag

Behaviour:
- Reset, checked every cycle and overriding everything: state S_A; op_a, op_b, op_sel, resultado = 0; sinal, op_start, busy, err, entry_b = 0; debouncer cleared.
- Key event generation:
  - A candidate exists when exactly one keys_n bit is 0.
  - The candidate must hold, with the same index, for DEBOUNCE_CYCLES consecutive cycles. The event then fires as a single one-cycle pulse plus a 4-bit code.
  - Zero or multiple low bits, or a change of index, restarts the count.
  - After an event, all keys must read high for DEBOUNCE_CYCLES cycles before the next event can fire. A held key therefore never repeats.
- Digit entry: operand <= (operand % 10)*10 + d. The operand always stays in 0..99.
- Events are processed in the cycle after the pulse. The new state and registers are visible 1 cycle after processing.
- S_A (entry_b=0):
  - digit -> update op_a.
  - * -> op_a=0.
  - # -> S_B.
  - A/B/C -> op_sel=0/1/2, go to S_ISSUE.
  - D -> clear op_a, op_b, resultado, sinal, err; stay in S_A.
- S_B (entry_b=1):
  - digit -> update op_b.
  - * -> S_A, op_b kept.
  - # -> ignored.
  - A/B/C -> as in S_A.
  - D -> as in S_A, then go to S_A.
- S_ISSUE: op_start=1 for exactly this cycle; err cleared; go to S_WAIT. op_a, op_b and op_sel are frozen from S_ISSUE until S_WAIT exits.
- S_WAIT:
  - alu_done is sampled only here, so a done pulse in the S_ISSUE cycle is ignored.
  - On alu_done: resultado<=alu_result, sinal<=alu_sign, go to S_SHOW.
  - If the timeout counter reaches TIMEOUT_CYCLES without done: err=1, resultado/sinal unchanged, go to S_SHOW.
  - All key events are dropped, not queued.
- S_SHOW:
  - digit d -> op_a=d, op_b=0, go to S_A.
  - A/B/C -> reissue with the current operands and the new op_sel.
  - * -> S_A.
  - # -> S_B.
  - D -> clear, go to S_A.
- A late alu_done arriving outside S_WAIT is ignored.
- rst in S_WAIT aborts the operation; no op_start is issued after reset.

Decomposition:
- Package calc_pkg:
  - key index constants KEY_A=10, KEY_B=11, KEY_C=12, KEY_D=13, KEY_AST=14, KEY_HASH=15
  - op_sel codes OP_ADD, OP_SUB, OP_MUL
  - state enum S_A, S_B, S_ISSUE, S_WAIT, S_SHOW
- Sub-module key_debounce_encoder:
  - inputs keys_n, clk, rst; parameter DEBOUNCE_CYCLES
  - outputs key_evt (1-cycle pulse) and key_code[3:0]
- calc_sequencer holds the FSM, operand registers, timeout counter and output latches.

Test Plan:
- Keys 1,2,#,3,4,A, each held 10 cycles and released 10 cycles; model answers done 3 cycles after op_start -> op_a=12, op_b=34, op_sel=0, one op_start pulse, resultado=46, sinal=0.
- 5,#,1,2,B with model returning 7/sign 1 -> op_sel=1, resultado=7, sinal=1; then C -> reissue, op_sel=2, resultado=60.
- 9,9,9,#,9,9,C -> op_a=99 (third digit shifts: 99), op_b=99, resultado=9801.
- Key 3 low for DEBOUNCE_CYCLES-1 cycles, then keys 3 and 4 low together for 20 cycles -> no key_evt, op_a stays 0.
- Press A with the model never asserting done -> busy for TIMEOUT_CYCLES, then err=1 with resultado unchanged; D -> err=0 and all registers 0.
- rst asserted 2 cycles after op_start, then alu_done pulsed -> state S_A, resultado=0, no op_start for 20 cycles.
